// File: rtl/inst_loader.sv
// Boot-image loader: parses a length-prefixed big-endian byte stream into 32-bit
// instruction-memory writes, then releases the CPU. Optional macro: INST_LOADER_CHECKSUM_EN.
module inst_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_rstb,
  output logic        busy,
  output logic        done,
  output logic        err
);

`ifdef INST_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR} state_t;
  localparam state_t S_FIN = S_CHK;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR} state_t;
  localparam state_t S_FIN = S_DONE;
`endif

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] len_q;
  logic [15:0] widx_q;
  logic [1:0]  bidx_q;
  logic [23:0] shift_q;
  logic        byte_ready_q;
  logic        wr_en_q;
  logic [31:0] wr_addr_q;
  logic [31:0] wr_data_q;
  logic        cpu_rstb_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  logic        xfer;
  logic [15:0] len_n;
  logic        word_end;
  logic        last_word;

  assign xfer      = byte_valid & byte_ready_q;
  assign len_n     = {len_q[15:8], byte_data};
  assign word_end  = (bidx_q == 2'd3);
  assign last_word = ((widx_q + 16'd1) == len_q);

  function automatic logic is_loading(input state_t s);
    logic r;
    r = (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA);
`ifdef INST_LOADER_CHECKSUM_EN
    r = r || (s == S_CHK);
`endif
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_LEN_HI;
      S_LEN_HI:       if (xfer) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if ({1'b0, len_n} > MAX_N) state_d = S_ERR;
          else if (len_n == 16'd0)   state_d = S_FIN;
          else                       state_d = S_DATA;
        end
      end
      S_DATA:         if (xfer && word_end && last_word) state_d = S_FIN;
`ifdef INST_LOADER_CHECKSUM_EN
      S_CHK:          if (xfer) state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
`endif
      S_ERR:          state_d = S_ERR;
      default:        state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change with it.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      widx_q       <= '0;
      bidx_q       <= '0;
      shift_q      <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= BASE_ADDR;
      wr_data_q    <= '0;
      cpu_rstb_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      byte_ready_q <= is_loading(state_d);
      busy_q       <= is_loading(state_d);
      done_q       <= (state_d == S_DONE);
      cpu_rstb_q   <= (state_d == S_DONE);
      err_q        <= (state_d == S_ERR);
      wr_en_q      <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            widx_q <= '0;
            bidx_q <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q <= '0;
`endif
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_q[15:8] <= byte_data;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ byte_data;
`endif
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len_q[7:0] <= byte_data;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ byte_data;
`endif
          end
        end
        S_DATA: begin
          if (xfer) begin
            bidx_q <= bidx_q + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ byte_data;
`endif
            if (word_end) begin
              wr_en_q   <= 1'b1;
              wr_data_q <= {shift_q, byte_data};
              wr_addr_q <= BASE_ADDR + {14'd0, widx_q, 2'b00};
              widx_q    <= widx_q + 16'd1;
            end else begin
              shift_q <= {shift_q[15:0], byte_data};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_rstb   = cpu_rstb_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: image-level model of expected writes and status,
// per-cycle write/consistency checker, plus literal expectations for the directed images.
module tb_inst_loader;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned MAXW = 256;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, wr_en, cpu_rstb, busy, done, err;
  logic [31:0] wr_addr, wr_data;

  int n_checks = 0;
  int n_pass = 0;

  logic [63:0] exp_q[$];
  logic [63:0] wr_log[$];

  inst_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rstb(rstb), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_rstb(cpu_rstb), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Per-cycle checker: every write must match the model queue; outputs hold otherwise.
  logic [31:0] prev_addr = BASE;
  logic [31:0] prev_data = '0;
  logic        prev_rstb = 1'b0;
  always @(negedge clk) begin
    logic [63:0] e;
    if (rstb) begin
      chk("cpu_rstb_eq_done", cpu_rstb, done);
      chk("ready_eq_busy", byte_ready, busy);
      if (wr_en) begin
        wr_log.push_back({wr_addr, wr_data});
        if (exp_q.size() == 0) chk("unexpected_wr", {63'd0, wr_en}, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e[63:32]);
          chk("wr_data", wr_data, e[31:0]);
        end
      end else if (prev_rstb) begin
        chk("wr_addr_hold", wr_addr, prev_addr);
        chk("wr_data_hold", wr_data, prev_data);
      end
    end
    prev_addr = wr_addr;
    prev_data = wr_data;
    prev_rstb = rstb;
  end

  // Image-level model: writes for each complete word plus the final status.
  task automatic model(input bq_t img, output bit e_done, output bit e_err);
    int unsigned n;
    logic [7:0] x;
    n = {16'd0, img[0], img[1]};
    x = img[0] ^ img[1];
    if (n > MAXW) begin
      e_done = 1'b0;
      e_err  = 1'b1;
      return;
    end
    for (int k = 0; k < int'(n); k++) begin
      int b;
      b = 2 + 4 * k;
      exp_q.push_back({BASE + 32'(4 * k), img[b], img[b+1], img[b+2], img[b+3]});
      x = x ^ img[b] ^ img[b+1] ^ img[b+2] ^ img[b+3];
    end
`ifdef INST_LOADER_CHECKSUM_EN
    e_err  = (img[2 + 4 * int'(n)] != x);
    e_done = !e_err;
`else
    e_done = 1'b1;
    e_err  = 1'b0;
`endif
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int n;
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 40) begin
      acc = byte_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("handshake", {63'd0, acc}, 64'd1);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_reset();
    rstb = 1'b0;
    @(posedge clk); #1;
    rstb = 1'b1;
  endtask

  task automatic run_load(input bq_t img, input bit gaps, input bit start_hold, input bit add_chk);
    bq_t full;
    bit e_done, e_err;
    int t;
    full = img;
`ifdef INST_LOADER_CHECKSUM_EN
    if (add_chk) begin
      logic [7:0] x;
      x = 8'h00;
      foreach (img[i]) x = x ^ img[i];
      full.push_back(x);
    end
`endif
    model(full, e_done, e_err);
    wr_log.delete();
    pulse_start();
    for (int i = 0; i < full.size(); i++) begin
      if (start_hold && i == 1) start = 1'b1;
      if (i == full.size() - 1) start = 1'b0;
      send_byte(full[i]);
      if (gaps) begin @(posedge clk); #1; end
    end
    t = 0;
    while (!(done || err) && t < 50) begin @(posedge clk); #1; t++; end
    repeat (2) begin @(posedge clk); #1; end
    chk("done", {63'd0, done}, {63'd0, e_done});
    chk("err", {63'd0, err}, {63'd0, e_err});
    chk("writes_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_byte_ready"}, byte_ready, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, BASE);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_cpu_rstb"}, cpu_rstb, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    bq_t big;
    rstb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rstb = 1'b1;
    @(posedge clk); #1;

    // two-word image, back-to-back
    run_load('{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01}, 0, 0, 1);
    chk("t1_nwr", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("t1_wr0", wr_log[0], {32'h0, 32'hDEADBEEF});
      chk("t1_wr1", wr_log[1], {32'h4, 32'h00000001});
    end
    chk("t1_done", done, 1);
    chk("t1_cpu_rstb", cpu_rstb, 1);

    // restart from DONE, valid toggling, start held high mid-load (ignored)
    run_load('{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78}, 1, 1, 1);
    chk("t2_nwr", wr_log.size(), 1);
    if (wr_log.size() == 1) chk("t2_wr0", wr_log[0], {32'h0, 32'h12345678});

    // zero-length image then a normal one
    run_load('{8'h00, 8'h00}, 0, 0, 1);
    chk("t3_nwr", wr_log.size(), 0);
    chk("t3_done", done, 1);
    run_load('{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD}, 0, 0, 1);
    chk("t3b_nwr", wr_log.size(), 1);
    if (wr_log.size() == 1) chk("t3b_wr0", wr_log[0], {32'h0, 32'hAABBCCDD});

    // exactly MAX_WORDS words is accepted
    big = '{8'h01, 8'h00};
    for (int k = 0; k < 256; k++) begin
      big.push_back(8'(k));
      big.push_back(~8'(k));
      big.push_back(8'h5A);
      big.push_back(8'(k) ^ 8'h3C);
    end
    run_load(big, 0, 0, 1);
    chk("t4_nwr", wr_log.size(), 256);
    if (wr_log.size() == 256) chk("t4_last", wr_log[255], {32'h3FC, 32'hFF005AC3});

    // reset mid-word aborts without a write, with reset winning over a byte transfer
    wr_log.delete();
    pulse_start();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
    byte_valid = 1'b1;
    byte_data  = 8'hCC;
    start      = 1'b1;
    pulse_reset();
    byte_valid = 1'b0;
    start      = 1'b0;
    chk_reset_outputs("abort");
    repeat (6) begin @(posedge clk); #1; end
    chk("abort_nwr", wr_log.size(), 0);
    chk("abort_idle_busy", busy, 0);

`ifdef INST_LOADER_CHECKSUM_EN
    run_load('{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45}, 0, 0, 0);
    chk("cs_ok_done", done, 1);
    if (wr_log.size() == 1) chk("cs_ok_wr0", wr_log[0], {32'h0, 32'h11223344});
    else chk("cs_ok_nwr", wr_log.size(), 1);
    run_load('{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h46}, 0, 0, 0);
    chk("cs_bad_err", err, 1);
    chk("cs_bad_cpu_rstb", cpu_rstb, 0);
    chk("cs_bad_nwr", wr_log.size(), 1);
    pulse_reset();
`endif

    // oversize length -> ERR, sticky against start, cleared only by reset
    run_load('{8'h01, 8'h01}, 0, 0, 0);
    chk("t5_err", err, 1);
    chk("t5_cpu_rstb", cpu_rstb, 0);
    chk("t5_nwr", wr_log.size(), 0);
    pulse_start();
    repeat (3) begin @(posedge clk); #1; end
    chk("t5_err_sticky", err, 1);
    chk("t5_busy", busy, 0);
    chk("t5_ready", byte_ready, 0);
    pulse_reset();
    chk("t5_err_cleared", err, 0);
    chk("t5_done_after_rst", done, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
